// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Types and constants shared by the RV32I fetch stage.
//                - XLEN, RESET_PC_DEFAULT, INSTR_NOP
//                - fetch_state_t : fetch FSM state encoding
//                - if_id_t       : IF/ID pipeline payload
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_TRAP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : IF/ID valid/ready handshake bundle.
//                master (fetch)  : drives out_valid/out_instr/out_pc/out_pc_plus4,
//                                  receives out_ready
//                slave  (decode) : the reverse
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID payload register with valid bit.
//                clk, rst  : clock, synchronous active-high reset
//                load      : capture d and set valid
//                flush     : clear valid (payload is left as-is)
//                d / q     : payload in / out
//                valid     : q holds a valid instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import riscv_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   rst,
  input  wire logic   load,
  input  wire logic   flush,
  input  wire if_id_t d,
  output logic        valid,
  output if_id_t      q
);

  logic   valid_d, valid_q;
  if_id_t payload_d, payload_q;

  // load and flush are never asserted together by the fetch unit; load wins
  // if they ever are.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (load) begin
      valid_d   = 1'b1;
      payload_d = d;
    end else if (flush) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '{instr: INSTR_NOP, pc: 32'h0, pc_plus4: 32'h0};
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid = valid_q;
  assign q     = payload_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : RV32I instruction-fetch stage. Owns the PC, drives the
//                combinational instruction memory, registers each fetched
//                word into an IF/ID valid/ready stage, takes redirects from
//                execute and traps on misaligned redirect targets.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                imem_addr/instr   instruction memory (same-cycle read)
//                redirect_valid/pc PC change request from execute
//                out_if (master)   IF/ID handshake + payload
//                fetch_trap        misaligned redirect trap pending
//                trap_addr         offending redirect target
//                fetch_count       accepted handshakes (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = riscv_pkg::XLEN
)(
  input  wire logic            clk,
  input  wire logic            rst,
  output logic [XLEN-1:0]      imem_addr,
  input  wire logic [XLEN-1:0] imem_instr,
  input  wire logic            redirect_valid,
  input  wire logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master         out_if,
  output logic                 fetch_trap,
  output logic [XLEN-1:0]      trap_addr,
  output logic [XLEN-1:0]      fetch_count
);

  fetch_state_t    state_d, state_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic            fetch_trap_d, fetch_trap_q;
  logic [XLEN-1:0] trap_addr_d, trap_addr_q;
  logic [XLEN-1:0] fetch_count_d, fetch_count_q;

  logic            out_valid;
  if_id_t          if_id_q;
  if_id_t          if_id_d;

  logic            redirect_take;
  logic            redirect_misaligned;
  logic            adv;
  logic            flush;
  logic            handshake;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH,
      S_TRAP: begin
        if (redirect_take) begin
          state_d = redirect_misaligned ? S_TRAP : S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs / control
  // --------------------------------------------------------------------------
  always_comb begin
    // Redirects are dropped during the boot cycle.
    redirect_take       = redirect_valid && (state_q != S_BOOT);
    redirect_misaligned = |redirect_pc[1:0];
    // Any redirect (even an ignored one) suppresses the fetch in its cycle;
    // in S_BOOT no fetch happens anyway, so this only matters in S_FETCH.
    adv       = (state_q == S_FETCH) && (!out_valid || out_if.out_ready) && !redirect_valid;
    handshake = out_valid && out_if.out_ready;
    // An accepted payload with nothing new behind it must drop valid, and a
    // redirect discards whatever is held, stalled or not.
    flush     = redirect_take || (out_if.out_ready && !adv);
  end

  // --------------------------------------------------------------------------
  // PC, trap and counter next-state
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d          = pc_q;
    fetch_trap_d  = fetch_trap_q;
    trap_addr_d   = trap_addr_q;
    fetch_count_d = fetch_count_q;

    if (redirect_take) begin
      if (redirect_misaligned) begin
        fetch_trap_d = 1'b1;
        trap_addr_d  = redirect_pc;
      end else begin
        fetch_trap_d = 1'b0;
        pc_d         = redirect_pc;
      end
    end else if (adv) begin
      pc_d = pc_q + XLEN'(4);
    end

    if (handshake) begin
      fetch_count_d = fetch_count_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      fetch_trap_q  <= 1'b0;
      trap_addr_q   <= '0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_trap_q  <= fetch_trap_d;
      trap_addr_q   <= trap_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // IF/ID stage
  // --------------------------------------------------------------------------
  always_comb begin
    if_id_d = '{instr: imem_instr, pc: pc_q, pc_plus4: pc_q + XLEN'(4)};
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (adv),
    .flush (flush),
    .d     (if_id_d),
    .valid (out_valid),
    .q     (if_id_q)
  );

  assign imem_addr           = pc_q;
  assign out_if.out_valid    = out_valid;
  assign out_if.out_instr    = if_id_q.instr;
  assign out_if.out_pc       = if_id_q.pc;
  assign out_if.out_pc_plus4 = if_id_q.pc_plus4;
  assign fetch_trap          = fetch_trap_q;
  assign trap_addr           = trap_addr_q;
  assign fetch_count         = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. Instruction
//                memory word i holds 32'hC0DE_0000 | (i << 2), so every
//                instruction encodes the word-aligned address it lives at.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        fetch_trap;
  logic [31:0] trap_addr;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [256];

  fetch_unit_if ifc ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_if         (ifc),
    .fetch_trap     (fetch_trap),
    .trap_addr      (trap_addr),
    .fetch_count    (fetch_count)
  );

  assign imem_instr = mem[imem_addr[9:2]];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".valid"},  {31'h0, ifc.out_valid}, 32'h0);
    check({tag, ".instr"},  ifc.out_instr,          32'h0000_0013);
    check({tag, ".pc"},     ifc.out_pc,             32'h0);
    check({tag, ".pc4"},    ifc.out_pc_plus4,       32'h0);
    check({tag, ".trap"},   {31'h0, fetch_trap},    32'h0);
    check({tag, ".taddr"},  trap_addr,              32'h0);
    check({tag, ".count"},  fetch_count,            32'h0);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    step();
    rst            = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hC0DE_0000 | (32'(i) << 2);
    end
    ifc.out_ready = 1'b1;

    // ---- 1: reset, boot cycle, streaming ----
    do_reset();
    check_reset_values("t1.rst");
    step();
    check("t1.boot_valid", {31'h0, ifc.out_valid}, 32'h0);
    step();
    check("t1.v0",  {31'h0, ifc.out_valid}, 32'h1);
    check("t1.pc0", ifc.out_pc,    32'h0000_0000);
    check("t1.in0", ifc.out_instr, 32'hC0DE_0000);
    step();
    check("t1.pc1", ifc.out_pc,    32'h0000_0004);
    check("t1.in1", ifc.out_instr, 32'hC0DE_0004);
    step();
    check("t1.pc2", ifc.out_pc,    32'h0000_0008);
    check("t1.in2", ifc.out_instr, 32'hC0DE_0008);
    step();
    check("t1.pc3", ifc.out_pc,    32'h0000_000C);
    check("t1.in3", ifc.out_instr, 32'hC0DE_000C);
    check("t1.p43", ifc.out_pc_plus4, 32'h0000_0010);
    step();
    check("t1.count4", fetch_count, 32'd4);

    // ---- 2: backpressure holds payload ----
    do_reset();
    step(); step(); step();               // boot, pc0, pc4
    ifc.out_ready = 1'b0;
    check("t2.addr", imem_addr, 32'h8);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2.hold_pc",    ifc.out_pc,    32'h4);
      check("t2.hold_instr", ifc.out_instr, 32'hC0DE_0004);
      check("t2.hold_valid", {31'h0, ifc.out_valid}, 32'h1);
      check("t2.hold_addr",  imem_addr,     32'h8);
    end
    check("t2.count_stall", fetch_count, 32'd1);
    ifc.out_ready = 1'b1;
    step();
    check("t2.rel_pc",    ifc.out_pc,  32'h8);
    check("t2.rel_count", fetch_count, 32'd2);
    step();
    check("t2.next_pc",   ifc.out_pc,  32'hC);

    // ---- 3: redirect flushes a stalled payload ----
    do_reset();
    step(); step(); step();               // boot, pc0, pc4
    ifc.out_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    check("t3.flush_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("t3.flush_count", fetch_count, 32'd1);
    redirect_valid = 1'b0;
    ifc.out_ready  = 1'b1;
    step();
    check("t3.pc40",    ifc.out_pc,    32'h40);
    check("t3.in40",    ifc.out_instr, 32'hC0DE_0040);
    check("t3.count",   fetch_count,   32'd1);

    // ---- 4: misaligned redirect traps, aligned redirect recovers ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    check("t4.trap",   {31'h0, fetch_trap},    32'h1);
    check("t4.taddr",  trap_addr,              32'h42);
    check("t4.valid",  {31'h0, ifc.out_valid}, 32'h0);
    check("t4.count",  fetch_count,            32'd2);
    redirect_valid = 1'b0;
    step(); step();
    check("t4.held_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("t4.held_trap",  {31'h0, fetch_trap},    32'h1);
    check("t4.held_addr",  imem_addr,              32'h44);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    check("t4.clr_trap",  {31'h0, fetch_trap},    32'h0);
    check("t4.clr_valid", {31'h0, ifc.out_valid}, 32'h0);
    redirect_valid = 1'b0;
    step();
    check("t4.pc80",   ifc.out_pc, 32'h80);
    check("t4.v80",    {31'h0, ifc.out_valid}, 32'h1);

    // ---- 5: PC wraps modulo 2^32 ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    check("t5.flush", {31'h0, ifc.out_valid}, 32'h0);
    redirect_valid = 1'b0;
    step();
    check("t5.pc_top",  ifc.out_pc,       32'hFFFF_FFFC);
    check("t5.p4_top",  ifc.out_pc_plus4, 32'h0);
    check("t5.in_top",  ifc.out_instr,    32'hC0DE_03FC);
    step();
    check("t5.pc_wrap", ifc.out_pc,       32'h0);
    check("t5.p4_wrap", ifc.out_pc_plus4, 32'h4);

    // ---- 6: reset mid-stream, boot redirect ignored, reset out of trap ----
    ifc.out_ready = 1'b0;                 // stalled with a valid payload
    check("t6.pre_valid", {31'h0, ifc.out_valid}, 32'h1);
    rst = 1'b1;
    step();
    check_reset_values("t6.rst");
    rst            = 1'b0;
    ifc.out_ready  = 1'b1;
    redirect_valid = 1'b1;                // lands in the boot cycle
    redirect_pc    = 32'h200;
    step();
    check("t6.boot_valid", {31'h0, ifc.out_valid}, 32'h0);
    redirect_valid = 1'b0;
    step();
    check("t6.restart_pc", ifc.out_pc, 32'h0);
    check("t6.restart_v",  {31'h0, ifc.out_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    step();
    check("t6.trap_set", {31'h0, fetch_trap}, 32'h1);
    redirect_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("t6.rst_trap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
